// File: rtl/mem_access_ctrl_if.sv
// CPU-side request bus and on-chip memory port handled by mem_access_ctrl.
// Handshake: Mem_OE/Mem_WE are level requests held until Mem_Ready pulses for one cycle; the
// requester must then drop both before the next request is accepted (a held request never retriggers).
interface mem_access_ctrl_if;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [9:0]  Switches;
    logic [15:0] mem_rdata;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rden;
    logic        mem_wren;
    logic [15:0] MDR_In;
    logic        Mem_Ready;
    logic [15:0] HEX_Data;

    modport slave (
        input  MAR, MDR, Mem_OE, Mem_WE, Switches, mem_rdata,
        output mem_addr, mem_wdata, mem_rden, mem_wren, MDR_In, Mem_Ready, HEX_Data
    );

    modport master (
        output MAR, MDR, Mem_OE, Mem_WE, Switches, mem_rdata,
        input  mem_addr, mem_wdata, mem_rden, mem_wren, MDR_In, Mem_Ready, HEX_Data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// CPU-to-on-chip-memory access controller with programmable read wait states.
// Optional MEM_IO_EN: address 16'hFFFF maps to board switches (read) and HEX latch (write).
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    mem_access_ctrl_if.slave   bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        io_q;
    logic        is_io;
    logic        start_wr;
    logic        start_rd;
    logic        rd_capture;
    logic        wr_finish;

`ifdef MEM_IO_EN
    assign is_io = (bus.MAR == 16'hFFFF);
`else
    logic unused_mar_hi;
    assign is_io         = 1'b0;
    assign unused_mar_hi = ^bus.MAR[15:10];
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Write wins over read when both requests arrive together.
    always_comb begin
        next_state = state;
        start_wr   = 1'b0;
        start_rd   = 1'b0;
        rd_capture = 1'b0;
        wr_finish  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Mem_WE) begin
                    start_wr   = 1'b1;
                    next_state = WR;
                end else if (bus.Mem_OE) begin
                    start_rd   = 1'b1;
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd1) begin
                    rd_capture = 1'b1;
                    next_state = DONE;
                end
            end
            WR: begin
                wr_finish  = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                if (!bus.Mem_OE && !bus.Mem_WE) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // I/O accesses walk the same states but never strobe the memory.
    assign bus.mem_rden = (state == RD_WAIT) && !io_q;
    assign bus.mem_wren = (state == WR) && !io_q;
    assign dbg_state    = state;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt           <= 4'd0;
            io_q          <= 1'b0;
            bus.mem_addr  <= 10'd0;
            bus.mem_wdata <= 16'd0;
            bus.MDR_In    <= 16'd0;
            bus.Mem_Ready <= 1'b0;
        end else begin
            bus.Mem_Ready <= rd_capture || wr_finish;
            if (start_wr) begin
                bus.mem_addr  <= bus.MAR[9:0];
                bus.mem_wdata <= bus.MDR;
                io_q          <= is_io;
            end
            if (start_rd) begin
                bus.mem_addr <= bus.MAR[9:0];
                io_q         <= is_io;
                cnt          <= is_io ? 4'd1 : WAIT_LD;
            end else if (state == RD_WAIT && !rd_capture) begin
                cnt <= cnt - 4'd1;
            end
            if (rd_capture) begin
                bus.MDR_In <= io_q ? {6'b0, bus.Switches} : bus.mem_rdata;
            end
        end
    end

`ifdef MEM_IO_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.HEX_Data <= 16'd0;
        end else if (start_wr && is_io) begin
            bus.HEX_Data <= bus.MDR;
        end
    end
`else
    assign bus.HEX_Data = 16'd0;
`endif

    a_ready_single: assert property (@(posedge Clk) disable iff (!Reset_n)
        bus.Mem_Ready |=> !bus.Mem_Ready);
    a_strobe_excl: assert property (@(posedge Clk) disable iff (!Reset_n)
        !(bus.mem_rden && bus.mem_wren));

endmodule
